// File: rtl/cdb_broadcast_arbiter_if.sv
// Bundle between the functional units and the common data bus arbiter.
// The unit side pushes results (master) and the arbiter drives the broadcast (slave).
interface cdb_broadcast_arbiter_if #(
    parameter int WIDTH  = 31,
    parameter int ROB    = 2,
    parameter int NUM_FU = 3
);
    logic [NUM_FU-1:0]            fuValid;
    logic [NUM_FU-1:0][WIDTH:0]   fuResult;
    logic [NUM_FU-1:0][ROB:0]     fuRob;
    logic [NUM_FU-1:0]            fuReady;
    logic [WIDTH:0]               cdbResult;
    logic [ROB:0]                 cdbRobEntry;
    logic                         cdbValidBroadcast;
    logic [NUM_FU-1:0]            cdbSource;

    modport master (
        output fuValid, fuResult, fuRob,
        input  fuReady, cdbResult, cdbRobEntry, cdbValidBroadcast, cdbSource
    );

    modport slave (
        input  fuValid, fuResult, fuRob,
        output fuReady, cdbResult, cdbRobEntry, cdbValidBroadcast, cdbSource
    );
endinterface

// File: rtl/cdb_broadcast_arbiter.sv
// Common data bus arbiter: per-unit FIFOs with head bypass, one registered broadcast per cycle.
// Define CDB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module cdb_broadcast_arbiter #(
    parameter int WIDTH  = 31,
    parameter int ROB    = 2,
    parameter int NUM_FU = 3,
    parameter int DEPTH  = 2
) (
    input  logic clk,
    input  logic globalReset,
    input  logic clear,
    input  logic validCommit,
    cdb_broadcast_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WIDTH + ROB + 2;
    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic              flush;
    logic [NUM_FU-1:0] ready;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] grant;
    logic [EW-1:0]     cand [NUM_FU];
    logic [EW-1:0]     win_entry;
    logic [PW-1:0]     win_idx;
    logic              win_any;

    logic [WIDTH:0]    cdb_result_reg;
    logic [ROB:0]      cdb_rob_reg;
    logic              cdb_valid_reg;
    logic [NUM_FU-1:0] cdb_source_reg;

    assign flush = globalReset | (clear & validCommit);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_unit
            logic [EW-1:0] mem_reg [DEPTH];
            logic [AW-1:0] rd_ptr_reg;
            logic [AW-1:0] wr_ptr_reg;
            logic [CW-1:0] count_reg;
            logic          empty;
            logic          pop;
            logic          write;

            assign empty     = (count_reg == '0);
            assign ready[gi] = (count_reg != CW'(DEPTH));
            assign push[gi]  = bus.fuValid[gi] & ready[gi];
            assign req[gi]   = !empty | push[gi];
            assign cand[gi]  = empty ? {bus.fuRob[gi], bus.fuResult[gi]} : mem_reg[rd_ptr_reg];
            // A granted push into an empty FIFO is broadcast directly and never stored.
            assign pop       = grant[gi] & !empty;
            assign write     = push[gi] & !(grant[gi] & empty);

            always_ff @(posedge clk) begin
                if (!flush && write) begin
                    mem_reg[wr_ptr_reg] <= {bus.fuRob[gi], bus.fuResult[gi]};
                end
            end

            always_ff @(posedge clk) begin
                if (flush) begin
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (write) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    case ({write, pop})
                        2'b10:   count_reg <= count_reg + CW'(1);
                        2'b01:   count_reg <= count_reg - CW'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

`ifdef CDB_FIXED_PRIO_EN
    always_comb begin
        win_idx = '0;
        win_any = 1'b0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (req[k]) begin
                win_idx = PW'(k);
                win_any = 1'b1;
            end
        end
    end
`else
    logic [PW-1:0] rr_ptr_reg;

    // Scan upward from rr_ptr_reg with wrap; the first requester found wins.
    always_comb begin
        int idx;
        idx     = 0;
        win_idx = '0;
        win_any = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_FU;
            if (!win_any && req[idx]) begin
                win_idx = PW'(idx);
                win_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            rr_ptr_reg <= '0;
        end else if (win_any) begin
            rr_ptr_reg <= (win_idx == PW'(NUM_FU - 1)) ? '0 : win_idx + PW'(1);
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (win_any) grant[win_idx] = 1'b1;
        win_entry = cand[win_idx];
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            cdb_valid_reg  <= 1'b0;
            cdb_source_reg <= '0;
            cdb_result_reg <= '0;
            cdb_rob_reg    <= '0;
        end else begin
            cdb_valid_reg  <= win_any;
            cdb_source_reg <= grant;
            if (win_any) {cdb_rob_reg, cdb_result_reg} <= win_entry;
        end
    end

    assign bus.fuReady           = ready;
    assign bus.cdbResult         = cdb_result_reg;
    assign bus.cdbRobEntry       = cdb_rob_reg;
    assign bus.cdbValidBroadcast = cdb_valid_reg;
    assign bus.cdbSource         = cdb_source_reg;
endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Directed bench for cdb_broadcast_arbiter in its default round-robin build.
module tb_cdb_broadcast_arbiter;
    logic clk = 1'b0;
    logic globalReset;
    logic clear;
    logic validCommit;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cdb_broadcast_arbiter_if bus ();

    cdb_broadcast_arbiter dut (
        .clk         (clk),
        .globalReset (globalReset),
        .clear       (clear),
        .validCommit (validCommit),
        .bus         (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Result word encodes unit and tag so a misrouted broadcast is visible.
    task automatic drive(input logic [2:0] v, input int t0, input int t1, input int t2);
        int t [3];
        t[0] = t0; t[1] = t1; t[2] = t2;
        bus.fuValid = v;
        for (int i = 0; i < 3; i++) begin
            bus.fuRob[i]    = 3'(t[i]);
            bus.fuResult[i] = 32'hA000_0000 | 32'(i << 8) | 32'(t[i]);
        end
    endtask

    task automatic apply_reset;
        globalReset = 1'b1;
        drive(3'b000, 0, 0, 0);
        tick();
        globalReset = 1'b0;
    endtask

    task automatic test_reset;
        globalReset = 1'b1;
        drive(3'b111, 1, 2, 3);
        tick();
        globalReset = 1'b0;
        drive(3'b000, 0, 0, 0);
        checks++;
        if (bus.cdbValidBroadcast !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.cdbValidBroadcast); end
        checks++;
        if (bus.cdbSource !== 3'b000) begin errors++; $display("FAIL reset_source got %b exp 000", bus.cdbSource); end
        checks++;
        if (bus.fuReady !== 3'b111) begin errors++; $display("FAIL reset_ready got %b exp 111", bus.fuReady); end
        tick();
        checks++;
        if (bus.cdbValidBroadcast !== 1'b0) begin errors++; $display("FAIL reset_push_dropped got valid %b exp 0", bus.cdbValidBroadcast); end
        $display("test_reset done");
    endtask

    task automatic test_single;
        apply_reset();
        drive(3'b001, 5, 0, 0);
        bus.fuResult[0] = 32'hDEADBEEF;
        tick();
        drive(3'b000, 0, 0, 0);
        checks++;
        if (bus.cdbValidBroadcast !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.cdbValidBroadcast); end
        checks++;
        if (bus.cdbRobEntry !== 3'd5) begin errors++; $display("FAIL single_rob got %0d exp 5", bus.cdbRobEntry); end
        checks++;
        if (bus.cdbResult !== 32'hDEADBEEF) begin errors++; $display("FAIL single_result got %h exp deadbeef", bus.cdbResult); end
        checks++;
        if (bus.cdbSource !== 3'b001) begin errors++; $display("FAIL single_source got %b exp 001", bus.cdbSource); end
        tick();
        checks++;
        if (bus.cdbValidBroadcast !== 1'b0 || bus.cdbSource !== 3'b000) begin
            errors++; $display("FAIL single_idle got valid %b src %b exp 0 000", bus.cdbValidBroadcast, bus.cdbSource);
        end
        checks++;
        if (bus.cdbRobEntry !== 3'd5 || bus.cdbResult !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_hold got rob %0d res %h exp 5 deadbeef", bus.cdbRobEntry, bus.cdbResult);
        end
        $display("test_single done");
    endtask

    task automatic test_contention;
        logic [2:0] pv [7] = '{3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000};
        int         pt [7] = '{1, 0, 0, 4, 0, 0, 0};
        logic       ev [7] = '{1, 1, 1, 1, 1, 1, 0};
        int         et [7] = '{1, 2, 3, 4, 5, 6, 0};
        logic [2:0] es [7] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};
        int         eu [7] = '{0, 1, 2, 0, 1, 2, 0};
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            drive(pv[c], pt[c], pt[c] + 1, pt[c] + 2);
            tick();
            checks++;
            if (bus.cdbValidBroadcast !== ev[c] || bus.cdbSource !== es[c]) begin
                errors++; $display("FAIL contention_c%0d got valid %b src %b exp %b %b", c, bus.cdbValidBroadcast, bus.cdbSource, ev[c], es[c]);
            end
            if (ev[c]) begin
                checks++;
                if (bus.cdbRobEntry !== 3'(et[c]) || bus.cdbResult !== (32'hA000_0000 | 32'(eu[c] << 8) | 32'(et[c]))) begin
                    errors++; $display("FAIL contention_data_c%0d got tag %0d res %h exp tag %0d", c, bus.cdbRobEntry, bus.cdbResult, et[c]);
                end
            end
        end
        $display("test_contention done");
    endtask

    task automatic test_full;
        logic [2:0] pv [8] = '{3'b010, 3'b111, 3'b111, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
        int         p0 [8] = '{0, 4, 5, 0, 0, 0, 0, 0};
        int         p1 [8] = '{7, 1, 2, 3, 0, 0, 0, 0};
        int         p2 [8] = '{0, 6, 0, 0, 0, 0, 0, 0};
        logic       ev [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        int         et [8] = '{7, 6, 4, 1, 0, 5, 2, 0};
        logic [2:0] es [8] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b000};
        logic [2:0] er [8] = '{3'b111, 3'b111, 3'b101, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            drive(pv[c], p0[c], p1[c], p2[c]);
            tick();
            checks++;
            if (bus.cdbValidBroadcast !== ev[c] || bus.cdbSource !== es[c]) begin
                errors++; $display("FAIL full_c%0d got valid %b src %b exp %b %b", c, bus.cdbValidBroadcast, bus.cdbSource, ev[c], es[c]);
            end
            if (ev[c]) begin
                checks++;
                if (bus.cdbRobEntry !== 3'(et[c])) begin
                    errors++; $display("FAIL full_tag_c%0d got %0d exp %0d", c, bus.cdbRobEntry, et[c]);
                end
            end
            checks++;
            if (bus.fuReady !== er[c]) begin
                errors++; $display("FAIL full_ready_c%0d got %b exp %b", c, bus.fuReady, er[c]);
            end
        end
        $display("test_full done");
    endtask

    task automatic test_flush;
        logic [2:0] pv [7] = '{3'b111, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        int         pt [7] = '{1, 4, 7, 0, 0, 0, 0};
        logic       cl [7] = '{0, 1, 1, 0, 0, 0, 0};
        logic       vc [7] = '{0, 0, 1, 0, 0, 0, 0};
        logic       ev [7] = '{1, 1, 0, 0, 0, 0, 0};
        int         et [7] = '{1, 2, 0, 0, 0, 0, 0};
        logic [2:0] es [7] = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        logic [2:0] er [7] = '{3'b111, 3'b011, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            if (c == 0) drive(pv[c], 1, 2, 3);
            else        drive(pv[c], pt[c], pt[c], pt[c]);
            clear       = cl[c];
            validCommit = vc[c];
            tick();
            clear       = 1'b0;
            validCommit = 1'b0;
            checks++;
            if (bus.cdbValidBroadcast !== ev[c] || bus.cdbSource !== es[c]) begin
                errors++; $display("FAIL flush_c%0d got valid %b src %b exp %b %b", c, bus.cdbValidBroadcast, bus.cdbSource, ev[c], es[c]);
            end
            if (c <= 2) begin
                checks++;
                if (bus.cdbRobEntry !== 3'(et[c])) begin
                    errors++; $display("FAIL flush_tag_c%0d got %0d exp %0d", c, bus.cdbRobEntry, et[c]);
                end
            end
            checks++;
            if (bus.fuReady !== er[c]) begin
                errors++; $display("FAIL flush_ready_c%0d got %b exp %b", c, bus.fuReady, er[c]);
            end
        end
        $display("test_flush done");
    endtask

    task automatic test_wrap;
        int sent = 0;
        int got  = 0;
        apply_reset();
        for (int c = 0; c < 60 && got < 10; c++) begin
            drive(3'b000, 0, 0, 0);
            if (c < 20 && bus.fuReady[0]) begin
                bus.fuValid[0]  = 1'b1;
                bus.fuResult[0] = 32'hFFFF_0000;
            end
            if (sent < 10 && bus.fuReady[1]) begin
                bus.fuValid[1]  = 1'b1;
                bus.fuRob[1]    = 3'(sent % 8);
                bus.fuResult[1] = 32'hB000_0000 + 32'(sent);
                sent++;
            end
            tick();
            checks++;
            if (bus.cdbValidBroadcast ? !$onehot(bus.cdbSource) : (bus.cdbSource !== 3'b000)) begin
                errors++; $display("FAIL wrap_onehot_c%0d got valid %b src %b", c, bus.cdbValidBroadcast, bus.cdbSource);
            end
            if (bus.cdbValidBroadcast && bus.cdbSource == 3'b010) begin
                checks++;
                if (bus.cdbResult !== 32'hB000_0000 + 32'(got) || bus.cdbRobEntry !== 3'(got % 8)) begin
                    errors++; $display("FAIL wrap_order got res %h tag %0d exp res %h", bus.cdbResult, bus.cdbRobEntry, 32'hB000_0000 + 32'(got));
                end
                got++;
            end
        end
        checks++;
        if (got != 10) begin errors++; $display("FAIL wrap_count got %0d exp 10", got); end
        $display("test_wrap done");
    endtask

    initial begin
        globalReset = 1'b1;
        clear       = 1'b0;
        validCommit = 1'b0;
        drive(3'b000, 0, 0, 0);
        tick();
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_flush();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
